// File: rtl/id_pipe_if.sv
// id_pipe_if: IF/ID, WB and EX-side signals of the ID stage in one bundle.
// The master modport is the surrounding pipeline and the slave modport is id_pipe.
interface id_pipe_if #(
    parameter int WIDTH = 32
);
    logic             if_valid_i;
    logic [31:0]      if_instr_i;
    logic [WIDTH-1:0] if_pc_i;
    logic             id_ready_o;
    logic             wb_load_i;
    logic [4:0]       wb_rd_i;
    logic [WIDTH-1:0] wb_data_i;
    logic             ex_ready_i;
    logic             flush_i;
    logic             idex_valid_o;
    logic [31:0]      idex_instr_o;
    logic [WIDTH-1:0] idex_pc_o;
    logic [WIDTH-1:0] idex_rs1_data_o;
    logic [WIDTH-1:0] idex_rs2_data_o;
    logic [WIDTH-1:0] idex_imm_o;
    logic [4:0]       idex_rd_o;
    logic             idex_br_en_o;

    modport master (
        output if_valid_i, if_instr_i, if_pc_i, wb_load_i, wb_rd_i, wb_data_i,
               ex_ready_i, flush_i,
        input  id_ready_o, idex_valid_o, idex_instr_o, idex_pc_o, idex_rs1_data_o,
               idex_rs2_data_o, idex_imm_o, idex_rd_o, idex_br_en_o
    );

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, wb_load_i, wb_rd_i, wb_data_i,
               ex_ready_i, flush_i,
        output id_ready_o, idex_valid_o, idex_instr_o, idex_pc_o, idex_rs1_data_o,
               idex_rs2_data_o, idex_imm_o, idex_rd_o, idex_br_en_o
    );
endinterface

// File: rtl/id_pipe.sv
// id_pipe: decode, register file, branch compare and ID/EX register with
// valid/ready handshake towards EX, load-use bubble insertion, flush and
// WB write-through. Optional performance counters are built when the macro
// ID_PIPE_PERF_CNT_EN is defined.
module id_pipe #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,   // 16 (RV32E) or 32 (RV32I)
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_pipe_if.slave         bus
`ifdef ID_PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic [WIDTH-1:0] r_rf [NUM_REGS];

    logic [6:0]        w_opcode;
    logic [4:0]        w_rd, w_rs1, w_rs2;
    logic [2:0]        w_funct3;
    logic [WIDTH-1:0]  w_rs1_data, w_rs2_data, w_imm;
    logic signed [31:0] w_imm32;
    logic              w_br_en, w_use_rs1, w_use_rs2, w_hazard;

    logic              r_valid_p1;
    logic [31:0]       r_instr_p1;
    logic [WIDTH-1:0]  r_pc_p1, r_rs1_p1, r_rs2_p1, r_imm_p1;
    logic [4:0]        r_rd_p1;
    logic              r_br_en_p1;

    assign w_opcode = bus.if_instr_i[6:0];
    assign w_rd     = bus.if_instr_i[11:7];
    assign w_funct3 = bus.if_instr_i[14:12];
    assign w_rs1    = bus.if_instr_i[19:15];
    assign w_rs2    = bus.if_instr_i[24:20];

    // Register file write port; indices beyond NUM_REGS and x0 are never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
        end else if (bus.wb_load_i && bus.wb_rd_i != 5'd0 && int'(bus.wb_rd_i) < NUM_REGS) begin
            r_rf[bus.wb_rd_i[RIDX_W-1:0]] <= bus.wb_data_i;
        end
    end

    // Operand read with WB write-through; x0 and out-of-range indices read 0
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rs1 != 5'd0 && int'(w_rs1) < NUM_REGS) begin
            if (bus.wb_load_i && bus.wb_rd_i == w_rs1) w_rs1_data = bus.wb_data_i;
            else                                       w_rs1_data = r_rf[w_rs1[RIDX_W-1:0]];
        end
        if (w_rs2 != 5'd0 && int'(w_rs2) < NUM_REGS) begin
            if (bus.wb_load_i && bus.wb_rd_i == w_rs2) w_rs2_data = bus.wb_data_i;
            else                                       w_rs2_data = r_rf[w_rs2[RIDX_W-1:0]];
        end
    end

    // Format-selected immediate, built at 32 bits then sign-extended to WIDTH
    always_comb begin
        w_imm32 = '0;
        case (w_opcode)
            OP_LOAD, OP_IMM, OP_JALR: w_imm32 = {{20{bus.if_instr_i[31]}}, bus.if_instr_i[31:20]};
            OP_STORE:  w_imm32 = {{20{bus.if_instr_i[31]}}, bus.if_instr_i[31:25], bus.if_instr_i[11:7]};
            OP_BRANCH: w_imm32 = {{19{bus.if_instr_i[31]}}, bus.if_instr_i[31], bus.if_instr_i[7],
                                  bus.if_instr_i[30:25], bus.if_instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC: w_imm32 = {bus.if_instr_i[31:12], 12'd0};
            OP_JAL:    w_imm32 = {{11{bus.if_instr_i[31]}}, bus.if_instr_i[31], bus.if_instr_i[19:12],
                                  bus.if_instr_i[20], bus.if_instr_i[30:21], 1'b0};
            default:   w_imm32 = '0;
        endcase
        w_imm = WIDTH'(w_imm32);
    end

    // Branch outcome on the bypassed operands
    always_comb begin
        w_br_en = 1'b0;
        if (w_opcode == OP_BRANCH) begin
            case (w_funct3)
                3'b000:  w_br_en = (w_rs1_data == w_rs2_data);
                3'b001:  w_br_en = (w_rs1_data != w_rs2_data);
                3'b100:  w_br_en = ($signed(w_rs1_data) <  $signed(w_rs2_data));
                3'b101:  w_br_en = ($signed(w_rs1_data) >= $signed(w_rs2_data));
                3'b110:  w_br_en = (w_rs1_data <  w_rs2_data);
                3'b111:  w_br_en = (w_rs1_data >= w_rs2_data);
                default: w_br_en = 1'b0;
            endcase
        end
    end

    // Load-use detection against the load currently held in ID/EX
    always_comb begin
        w_use_rs1 = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
        w_use_rs2 = (w_opcode == OP_BRANCH || w_opcode == OP_STORE || w_opcode == OP_OP);
        w_hazard  = bus.if_valid_i && r_valid_p1 && (r_instr_p1[6:0] == OP_LOAD) &&
                    (r_rd_p1 != 5'd0) &&
                    ((w_use_rs1 && w_rs1 == r_rd_p1) || (w_use_rs2 && w_rs2 == r_rd_p1));
    end

    assign bus.id_ready_o = bus.flush_i | (bus.ex_ready_i & ~w_hazard);

    // ID/EX register: reset > flush > hold on back-pressure > hazard bubble > capture
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i || (bus.ex_ready_i && (w_hazard || !bus.if_valid_i))) begin
            r_valid_p1 <= 1'b0;
            r_instr_p1 <= NOP;
            r_pc_p1    <= '0;
            r_rs1_p1   <= '0;
            r_rs2_p1   <= '0;
            r_imm_p1   <= '0;
            r_rd_p1    <= '0;
            r_br_en_p1 <= 1'b0;
        end else if (bus.ex_ready_i) begin
            r_valid_p1 <= 1'b1;
            r_instr_p1 <= bus.if_instr_i;
            r_pc_p1    <= bus.if_pc_i;
            r_rs1_p1   <= w_rs1_data;
            r_rs2_p1   <= w_rs2_data;
            r_imm_p1   <= w_imm;
            r_rd_p1    <= w_rd;
            r_br_en_p1 <= w_br_en;
        end
    end

    assign bus.idex_valid_o    = r_valid_p1;
    assign bus.idex_instr_o    = r_instr_p1;
    assign bus.idex_pc_o       = r_pc_p1;
    assign bus.idex_rs1_data_o = r_rs1_p1;
    assign bus.idex_rs2_data_o = r_rs2_p1;
    assign bus.idex_imm_o      = r_imm_p1;
    assign bus.idex_rd_o       = r_rd_p1;
    assign bus.idex_br_en_o    = r_br_en_p1;

`ifdef ID_PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard && bus.ex_ready_i && !bus.flush_i && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bus.flush_i && bus.if_valid_i && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed and randomized checks of id_pipe against a
// behavioural model of the ID stage (architectural register array plus
// expected ID/EX contents). A second instance runs with NUM_REGS=16.
module tb_id_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_pipe_if #(.WIDTH(W)) bus ();
    id_pipe_if #(.WIDTH(W)) bus_e ();

`ifdef ID_PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt, stall_cnt_e, flush_cnt_e;
`endif

    id_pipe #(.WIDTH(W), .NUM_REGS(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
`ifdef ID_PIPE_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    id_pipe #(.WIDTH(W), .NUM_REGS(16), .CNT_W(16)) dut_e (
        .clk(clk), .rst(rst), .bus(bus_e)
`ifdef ID_PIPE_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_e), .flush_cnt_o(flush_cnt_e)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;
    logic        m_br;
    int          m_stall_cnt, m_flush_cnt;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2, input logic [2:0] f3, input logic [6:0] op);
        return {7'd0, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, rs1, input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs1, rs2, input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_load_i && bus.wb_rd_i == idx) return bus.wb_data_i;
        return m_rf[idx];
    endfunction

    // Immediates computed with arithmetic shifts of the whole word
    function automatic logic [31:0] m_imm_of(input logic [31:0] ins);
        int s;
        s = ins;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return 32'(s >>> 20);
            7'h23: return 32'(((s >>> 25) <<< 5)) | 32'(ins[11:7]);
            7'h63: return 32'(((s >>> 31) <<< 12)) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'h37, 7'h17: return ins & 32'hFFFFF000;
            7'h6F: return 32'(((s >>> 31) <<< 20)) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_br_of(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (ins[6:0] != 7'h63) return 1'b0;
        case (ins[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_hazard();
        logic [31:0] ins;
        logic u1, u2;
        ins = bus.if_instr_i;
        u1 = !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6F);
        u2 = (ins[6:0] == 7'h63 || ins[6:0] == 7'h23 || ins[6:0] == 7'h33);
        if (!bus.if_valid_i || !m_valid || m_instr[6:0] != 7'h03 || m_rd == 5'd0) return 1'b0;
        return (u1 && ins[19:15] == m_rd) || (u2 && ins[24:20] == m_rd);
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic exr,
                         input logic fl, input logic wl, input logic [4:0] wrd, input logic [31:0] wd);
        bus.if_valid_i = v;
        bus.if_instr_i = ins;
        bus.if_pc_i    = pc;
        bus.ex_ready_i = exr;
        bus.flush_i    = fl;
        bus.wb_load_i  = wl;
        bus.wb_rd_i    = wrd;
        bus.wb_data_i  = wd;
    endtask

    // One clock of the main instance: check handshake, advance model, check ID/EX
    task automatic step(input string name);
        logic haz, exp_rdy, bub, cap;
        logic [31:0] c_rs1, c_rs2;
        logic [166:0] exp_v, act_v;
        #2;
        haz = m_hazard();
        exp_rdy = bus.flush_i | (bus.ex_ready_i & ~haz);
        if (!rst) begin
            checks++;
            if (bus.id_ready_o !== exp_rdy) begin
                errors++;
                $display("FAIL %s id_ready: got %b expected %b", name, bus.id_ready_o, exp_rdy);
            end
        end
        bub = rst || bus.flush_i || (bus.ex_ready_i && (haz || !bus.if_valid_i));
        cap = !bub && bus.ex_ready_i;
        c_rs1 = m_read(bus.if_instr_i[19:15]);
        c_rs2 = m_read(bus.if_instr_i[24:20]);
        @(posedge clk);
        if (bub) begin
            m_valid = 0; m_instr = 32'h13; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0; m_br = 0;
        end else if (cap) begin
            m_valid = 1; m_instr = bus.if_instr_i; m_pc = bus.if_pc_i; m_rs1 = c_rs1; m_rs2 = c_rs2;
            m_imm = m_imm_of(bus.if_instr_i); m_rd = bus.if_instr_i[11:7];
            m_br = m_br_of(bus.if_instr_i, c_rs1, c_rs2);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (bus.wb_load_i && bus.wb_rd_i != 0) m_rf[bus.wb_rd_i] = bus.wb_data_i;
            if (haz && bus.ex_ready_i && !bus.flush_i && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
            if (bus.flush_i && bus.if_valid_i && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
        end
        #1;
        exp_v = {m_valid, m_instr, m_pc, m_rs1, m_rs2, m_imm, m_rd, m_br};
        act_v = {bus.idex_valid_o, bus.idex_instr_o, bus.idex_pc_o, bus.idex_rs1_data_o,
                 bus.idex_rs2_data_o, bus.idex_imm_o, bus.idex_rd_o, bus.idex_br_en_o};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s idex: got %h expected %h", name, act_v, exp_v);
        end
`ifdef ID_PIPE_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 16'(m_stall_cnt) || flush_cnt !== 16'(m_flush_cnt)) begin
            errors++;
            $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", name, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, enc_r(6, 5, 0, 0, 7'h33), 32'h100, 1, 1, 1, 5, 32'h55);
        step("reset0");
        step("reset1");
        checks++;
        if (bus.idex_valid_o !== 1'b0 || bus.idex_instr_o !== 32'h13) begin
            errors++;
            $display("FAIL reset_vi: got %b/%h expected 0/00000013", bus.idex_valid_o, bus.idex_instr_o);
        end
        checks++;
        if ({bus.idex_pc_o, bus.idex_rs1_data_o, bus.idex_rs2_data_o, bus.idex_imm_o, bus.idex_rd_o, bus.idex_br_en_o} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got pc=%h rs1=%h rs2=%h imm=%h rd=%0d br=%b expected all 0",
                     bus.idex_pc_o, bus.idex_rs1_data_o, bus.idex_rs2_data_o, bus.idex_imm_o, bus.idex_rd_o, bus.idex_br_en_o);
        end
        rst = 1'b0;
        drive(0, 32'h13, 0, 1, 0, 0, 0, 0);
        step("post_reset");
    endtask

    task automatic test_bypass();
        drive(1, enc_r(6, 5, 0, 0, 7'h33), 32'h200, 1, 0, 1, 5, 32'hDEADBEEF);
        step("bypass");
        checks++;
        if (bus.idex_rs1_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_rs1: got %h expected deadbeef", bus.idex_rs1_data_o);
        end
        drive(1, enc_r(7, 5, 5, 0, 7'h33), 32'h204, 1, 0, 0, 0, 0);
        step("rf_read");
        checks++;
        if (bus.idex_rs2_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rf_read_rs2: got %h expected deadbeef", bus.idex_rs2_data_o);
        end
    endtask

    task automatic test_load_use();
        drive(1, enc_i(3, 1, 12'd0, 3'd2, 7'h03), 32'h300, 1, 0, 0, 0, 0);
        step("lu_load");
        drive(1, enc_r(4, 3, 2, 0, 7'h33), 32'h304, 1, 0, 0, 0, 0);
        #2;
        checks++;
        if (bus.id_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL lu_ready_stall: got %b expected 0", bus.id_ready_o);
        end
        step("lu_bubble");
        checks++;
        if (bus.idex_valid_o !== 1'b0 || bus.idex_instr_o !== 32'h13) begin
            errors++;
            $display("FAIL lu_bubble: got %b/%h expected 0/00000013", bus.idex_valid_o, bus.idex_instr_o);
        end
        #2;
        checks++;
        if (bus.id_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL lu_ready_resume: got %b expected 1", bus.id_ready_o);
        end
        step("lu_capture");
        checks++;
        if (bus.idex_valid_o !== 1'b1 || bus.idex_instr_o !== enc_r(4, 3, 2, 0, 7'h33)) begin
            errors++;
            $display("FAIL lu_capture: got %b/%h expected 1/%h", bus.idex_valid_o, bus.idex_instr_o, enc_r(4, 3, 2, 0, 7'h33));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_instr;
        held_instr = m_instr;
        for (int i = 0; i < 3; i++) begin
            drive(1, enc_i(9, 6, 12'h7FF, 3'd0, 7'h13), 32'h400, 0, 0, 0, 0, 0);
            step("backpressure");
            checks++;
            if (bus.idex_instr_o !== held_instr || bus.idex_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got %b/%h expected 1/%h", bus.idex_valid_o, bus.idex_instr_o, held_instr);
            end
        end
    endtask

    task automatic test_flush();
        int fc0;
        fc0 = m_flush_cnt;
        drive(1, enc_b(1, 2, 13'd16, 3'd0), 32'h500, 0, 1, 0, 0, 0);
        step("flush");
        checks++;
        if (bus.idex_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b expected 0", bus.idex_valid_o);
        end
        checks++;
        if (m_flush_cnt != fc0 + 1) begin
            errors++;
            $display("FAIL flush_model_count: got %0d expected %0d", m_flush_cnt, fc0 + 1);
        end
    endtask

    task automatic test_branch();
        drive(0, 32'h13, 0, 1, 0, 1, 1, 32'hFFFFFFFF);
        step("br_wb1");
        drive(0, 32'h13, 0, 1, 0, 1, 2, 32'h1);
        step("br_wb2");
        drive(1, enc_b(1, 2, -13'sd8, 3'd4), 32'h600, 1, 0, 0, 0, 0);
        step("blt");
        checks++;
        if (bus.idex_br_en_o !== 1'b1 || bus.idex_imm_o !== 32'hFFFFFFF8) begin
            errors++;
            $display("FAIL blt: got br=%b imm=%h expected br=1 imm=fffffff8", bus.idex_br_en_o, bus.idex_imm_o);
        end
        drive(1, enc_b(1, 2, 13'd8, 3'd6), 32'h604, 1, 0, 0, 0, 0);
        step("bltu");
        checks++;
        if (bus.idex_br_en_o !== 1'b0 || bus.idex_imm_o !== 32'h8) begin
            errors++;
            $display("FAIL bltu: got br=%b imm=%h expected br=0 imm=00000008", bus.idex_br_en_o, bus.idex_imm_o);
        end
    endtask

    task automatic step_e();
        @(posedge clk);
        #1;
    endtask

    task automatic test_rv32e();
        bus_e.ex_ready_i = 1; bus_e.flush_i = 0; bus_e.if_pc_i = 32'h700;
        bus_e.if_valid_i = 1; bus_e.if_instr_i = enc_r(7, 20, 0, 0, 7'h33);
        bus_e.wb_load_i = 1; bus_e.wb_rd_i = 20; bus_e.wb_data_i = 32'h1234;
        step_e();
        checks++;
        if (bus_e.idex_rs1_data_o !== 32'd0) begin
            errors++;
            $display("FAIL e_x20_bypass: got %h expected 0", bus_e.idex_rs1_data_o);
        end
        bus_e.wb_load_i = 0;
        step_e();
        checks++;
        if (bus_e.idex_rs1_data_o !== 32'd0 || bus_e.idex_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL e_x20_read: got %h/%b expected 0/1", bus_e.idex_rs1_data_o, bus_e.idex_valid_o);
        end
        bus_e.wb_load_i = 1; bus_e.wb_rd_i = 5; bus_e.wb_data_i = 32'hABCD; bus_e.if_valid_i = 0;
        step_e();
        bus_e.wb_load_i = 0; bus_e.if_valid_i = 1; bus_e.if_instr_i = enc_r(7, 5, 0, 0, 7'h33);
        step_e();
        checks++;
        if (bus_e.idex_rs1_data_o !== 32'hABCD) begin
            errors++;
            $display("FAIL e_x5_read: got %h expected 0000abcd", bus_e.idex_rs1_data_o);
        end
        bus_e.if_valid_i = 0;
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [31:0] ins;
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B};
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            if (ins[6:0] == 7'h03 && $urandom_range(0, 1) == 1) ins[6:0] = 7'h03;
            drive($urandom_range(0, 9) < 8, ins, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            step("random");
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        m_valid = 0; m_instr = 32'h13; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0; m_br = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
        bus_e.if_valid_i = 0; bus_e.if_instr_i = 32'h13; bus_e.if_pc_i = 0; bus_e.ex_ready_i = 1;
        bus_e.flush_i = 0; bus_e.wb_load_i = 0; bus_e.wb_rd_i = 0; bus_e.wb_data_i = 0;
        test_reset();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_flush();
        test_branch();
        test_rv32e();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
